// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 0101 serial pattern detector and its scan controller.
package seq_detect_pkg;

   // Detector core states, named after the suffix of the bit stream seen so far.
   // R0 is also the cleared state: it behaves as if the last bit seen was a 1.
   typedef enum logic [1:0] {
      R0    = 2'd0,
      RZ    = 2'd1,
      Z20   = 2'd2,
      Z202Z = 2'd3
   } det_state_t;

   // Scan controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/seq0101_core.sv
// Overlapping 0101 detector core. It is a Mealy machine: z is high in the
// cycle that the completing 1 is presented on x. The state only advances
// while en is high, and a synchronous clear returns it to R0.
module seq0101_core
   import seq_detect_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   input  logic x,
   output logic z
);

   det_state_t state;
   det_state_t next_state;

   // Next-state and Mealy output. When en is low the state holds and z stays low.
   always_comb begin
      next_state = state;
      z          = 1'b0;
      if (en) begin
         case (state)
            R0:      next_state = x ? R0  : RZ;
            RZ:      next_state = x ? Z20 : RZ;
            Z20:     next_state = x ? R0  : Z202Z;
            Z202Z: begin
               next_state = x ? Z20 : RZ;
               z          = x;
            end
            default: next_state = R0;
         endcase
      end
   end

   // State register; clear wins over normal advance so a new word starts fresh.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= R0;
      end else if (clear) begin
         state <= R0;
      end else begin
         state <= next_state;
      end
   end

endmodule

// File: rtl/seq_scan_controller.sv
// Scan controller: captures a word on start and feeds it MSB-first into the
// 0101 detector core, one bit per clock. It counts detections (saturating),
// records the bit index of the first match and pulses done for one cycle
// after the last bit. abort during a scan drops back to IDLE with the results
// cleared and no done pulse.
module seq_scan_controller
   import seq_detect_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic               serial_bit,
   output logic               detect,
   output logic [COUNT_W-1:0] match_count,
   output logic               first_valid,
   output logic [COUNT_W-1:0] first_pos
);

   localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(WIDTH - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   ctrl_state_t        state;
   ctrl_state_t        next_state;
   logic [WIDTH-1:0]   shreg;
   logic [COUNT_W-1:0] bit_idx;
   logic               accept;
   logic               shifting;
   logic               last_bit;
   logic               det_z;

   assign shifting   = (state == SHIFT);
   assign last_bit   = (bit_idx == LAST_IDX);
   assign busy       = shifting;
   assign done       = (state == DONE);
   assign serial_bit = shifting ? shreg[WIDTH-1] : 1'b0;
   assign detect     = det_z;

   seq0101_core u_core (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept),
      .en      (shifting),
      .x       (serial_bit),
      .z       (det_z)
   );

   // Controller state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. start is only honoured in IDLE or DONE, so a scan can
   // follow the previous one with no idle gap; abort only matters in SHIFT.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               next_state = IDLE;
            end else if (last_bit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: word capture, shifting, match counting and first-match capture.
   // Results are only touched on an accepted start or during SHIFT, so they
   // hold through DONE and IDLE for the host to read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg       <= '0;
         bit_idx     <= '0;
         match_count <= '0;
         first_valid <= 1'b0;
         first_pos   <= '0;
      end else if (accept) begin
         shreg       <= data_in;
         bit_idx     <= '0;
         match_count <= '0;
         first_valid <= 1'b0;
         first_pos   <= '0;
      end else if (shifting) begin
         if (abort) begin
            bit_idx     <= '0;
            match_count <= '0;
            first_valid <= 1'b0;
            first_pos   <= '0;
         end else begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_idx <= bit_idx + COUNT_W'(1);
            if (det_z) begin
               if (match_count != COUNT_MAX) begin
                  match_count <= match_count + COUNT_W'(1);
               end
               if (!first_valid) begin
                  first_valid <= 1'b1;
                  first_pos   <= bit_idx;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_scan_controller.sv
// Testbench for seq_scan_controller: a sliding-window reference model fills a
// scoreboard with per-bit and per-scan expectations when a word is started,
// and a monitor pops and compares them as the DUT shifts and completes.
module tb_seq_scan_controller;

   localparam int WIDTH   = 16;
   localparam int COUNT_W = 5;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               start;
   logic               abort;
   logic [WIDTH-1:0]   data_in;
   logic               busy;
   logic               done;
   logic               serial_bit;
   logic               detect;
   logic [COUNT_W-1:0] match_count;
   logic               first_valid;
   logic [COUNT_W-1:0] first_pos;

   typedef struct {
      logic sbit;
      logic det;
   } bit_exp_t;

   typedef struct {
      int cnt;
      int fv;
      int fp;
      int start_cyc;
   } res_exp_t;

   bit_exp_t bit_q[$];
   res_exp_t res_q[$];

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int busy_cycles  = 0;
   int done_seen    = 0;

   seq_scan_controller #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .data_in     (data_in),
      .busy        (busy),
      .done        (done),
      .serial_bit  (serial_bit),
      .detect      (detect),
      .match_count (match_count),
      .first_valid (first_valid),
      .first_pos   (first_pos)
   );

   // Free-running clock and cycle counter.
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Reference model: a detection sits at index i when bits i-3..i of the
   // MSB-first stream are 0,1,0,1. The detector is cleared per word, so only
   // bits of this word can contribute.
   function automatic void model_scan(input logic [WIDTH-1:0] w, output int cnt,
                                      output int fv, output int fp,
                                      output logic [WIDTH-1:0] det);
      logic [WIDTH-1:0] b;
      cnt = 0;
      fv  = 0;
      fp  = 0;
      det = '0;
      for (int i = 0; i < WIDTH; i++) b[i] = w[WIDTH-1-i];
      for (int i = 3; i < WIDTH; i++) begin
         if (!b[i-3] && b[i-2] && !b[i-1] && b[i]) begin
            det[i] = 1'b1;
            if (cnt < (1 << COUNT_W) - 1) cnt++;
            if (fv == 0) begin
               fv = 1;
               fp = i;
            end
         end
      end
   endfunction

   // Presents a start with word w for one edge and loads the scoreboard.
   // Returns 1 time unit after the accepting edge (bit index 0 cycle).
   task automatic applyStimulus(input logic [WIDTH-1:0] w);
      int               cnt;
      int               fv;
      int               fp;
      logic [WIDTH-1:0] det;
      res_exp_t         r;
      bit_exp_t         e;
      start   = 1'b1;
      data_in = w;
      @(posedge clock);
      #1;
      start = 1'b0;
      model_scan(w, cnt, fv, fp, det);
      for (int i = 0; i < WIDTH; i++) begin
         e.sbit = w[WIDTH-1-i];
         e.det  = det[i];
         bit_q.push_back(e);
      end
      r.cnt       = cnt;
      r.fv        = fv;
      r.fp        = fp;
      r.start_cyc = cyc;
      res_q.push_back(r);
   endtask

   // Waits (bounded) for done; returns at the falling edge where done is high.
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (n < 100) begin
         @(negedge clock);
         if (done) break;
         n++;
      end
      if (!done) checkOutput({tag, "_done_timeout"}, 0, 1);
   endtask

   task automatic flush_scoreboard();
      bit_q.delete();
      res_q.delete();
      busy_cycles = 0;
   endtask

   // Monitor: per-bit serial/detect checks while busy, result checks on done.
   always @(negedge clock) begin
      if (reset_n) begin
         if (busy) begin
            busy_cycles++;
            if (bit_q.size() == 0) begin
               checkOutput("unexpected_busy", 1, 0);
            end else begin
               bit_exp_t e;
               e = bit_q.pop_front();
               checkOutput("serial_bit", serial_bit, e.sbit);
               checkOutput("detect", detect, e.det);
            end
         end
         if (done) begin
            done_seen++;
            if (res_q.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               res_exp_t r;
               r = res_q.pop_front();
               checkOutput("match_count", match_count, r.cnt);
               checkOutput("first_valid", first_valid, r.fv);
               checkOutput("first_pos", first_pos, r.fp);
               checkOutput("done_latency", cyc - r.start_cyc, WIDTH);
               checkOutput("busy_cycles", busy_cycles, WIDTH);
               checkOutput("busy_in_done", busy, 0);
            end
            busy_cycles = 0;
         end
      end
   end

   // Hard stop if the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int d0;
      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      data_in = '0;

      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_serial_bit", serial_bit, 0);
      checkOutput("rst_detect", detect, 0);
      checkOutput("rst_match_count", match_count, 0);
      checkOutput("rst_first_valid", first_valid, 0);
      checkOutput("rst_first_pos", first_pos, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Alternating pattern: matches at 3,5,...,15.
      applyStimulus(16'h5555);
      wait_done("s5555");
      checkOutput("s5555_count", match_count, 7);
      checkOutput("s5555_first_pos", first_pos, 3);
      checkOutput("s5555_first_valid", first_valid, 1);
      repeat (3) @(negedge clock);
      checkOutput("hold_count", match_count, 7);
      checkOutput("hold_first_pos", first_pos, 3);
      checkOutput("hold_done_low", done, 0);

      // All ones: no detections.
      applyStimulus(16'hFFFF);
      wait_done("sFFFF");
      checkOutput("sFFFF_count", match_count, 0);
      checkOutput("sFFFF_first_valid", first_valid, 0);
      @(negedge clock);

      // Single detection mid-word.
      applyStimulus(16'h0A00);
      wait_done("s0A00");
      checkOutput("s0A00_count", match_count, 1);
      checkOutput("s0A00_first_pos", first_pos, 6);
      @(negedge clock);

      // Detection on the final bit, then a back-to-back start from DONE.
      applyStimulus(16'h0005);
      wait_done("s0005");
      checkOutput("s0005_count", match_count, 1);
      checkOutput("s0005_first_pos", first_pos, 15);
      applyStimulus(16'h4000);
      checkOutput("b2b_busy", busy, 1);
      wait_done("s4000");
      checkOutput("s4000_count", match_count, 0);
      checkOutput("s4000_first_valid", first_valid, 0);
      @(negedge clock);

      // Abort at bit index 5, with an ignored start pulse at bit index 2.
      applyStimulus(16'h5555);
      repeat (2) @(posedge clock);
      #1;
      start   = 1'b1;
      data_in = 16'hFFFF;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      abort = 1'b1;
      @(posedge clock);
      #1;
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_count", match_count, 0);
      checkOutput("abort_first_valid", first_valid, 0);
      flush_scoreboard();
      d0 = done_seen;
      repeat (20) @(negedge clock);
      checkOutput("abort_no_done", done_seen - d0, 0);
      checkOutput("abort_idle_busy", busy, 0);

      // Asynchronous reset in the middle of a scan at bit index 9.
      applyStimulus(16'h5555);
      repeat (9) @(posedge clock);
      #2;
      checkOutput("prereset_count", match_count, 3);
      d0 = done_seen;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_done", done, 0);
      checkOutput("arst_serial_bit", serial_bit, 0);
      checkOutput("arst_detect", detect, 0);
      checkOutput("arst_match_count", match_count, 0);
      checkOutput("arst_first_valid", first_valid, 0);
      checkOutput("arst_first_pos", first_pos, 0);
      flush_scoreboard();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("arst_no_done", done_seen - d0, 0);

      // Fresh scan after reset.
      applyStimulus(16'h5555);
      wait_done("post_reset");
      checkOutput("post_reset_count", match_count, 7);
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
